// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host agent: controller command codes,
// host FSM state encoding and image/checksum sizing constants.
package lcd_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE = 4'd0,
    CMD_UP    = 4'd1,
    CMD_DOWN  = 4'd2,
    CMD_LEFT  = 4'd3,
    CMD_RIGHT = 4'd4,
    CMD_MAX   = 4'd5,
    CMD_MIN   = 4'd6,
    CMD_AVG   = 4'd7,
    CMD_CCW   = 4'd8,
    CMD_CW    = 4'd9,
    CMD_MIRX  = 4'd10,
    CMD_MIRY  = 4'd11
  } lcd_cmd_e;

  localparam logic [2:0] ST_LOAD    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_RESULT  = 3'd5;

  localparam int IMG_PIXELS = 64;
  localparam int CHK_W      = 14;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command queue with full/empty flags and a sticky overflow flag.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module lcd_cmd_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic         ovf_q, ovf_d;
  logic         push_ok, pop_ok;
  logic [W-1:0] mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q[PW-1:0]];
  assign ovf     = ovf_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok)         wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)          rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !push_ok) ovf_d   = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lcd_host_agent.sv
// System-side agent for the 8x8 LCD image controller: image ROM responder,
// command issuer and write-back capture. Define LCD_HOST_ORDER_CHECK_EN to
// enable the write-back address order checker driving err.
module lcd_host_agent
  import lcd_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 6,
  parameter int CQ_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             img_wr_en,
  input  logic [AW-1:0]    img_wr_addr,
  input  logic [DW-1:0]    img_wr_data,
  input  logic             cq_push,
  input  logic [3:0]       cq_data,
  output logic             cq_full,
  output logic             cq_ovf,
  input  logic             IROM_rd,
  input  logic [AW-1:0]    IROM_A,
  output logic [DW-1:0]    IROM_Q,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             IRAM_valid,
  input  logic [AW-1:0]    IRAM_A,
  input  logic [DW-1:0]    IRAM_D,
  input  logic             done,
  input  logic [AW-1:0]    res_rd_addr,
  output logic [DW-1:0]    res_rd_data,
  output logic [CHK_W-1:0] checksum,
  output logic [6:0]       wr_count,
  output logic             result_valid,
  output logic             err
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [6:0] FULL_CNT = 7'(IMG_PIXELS);

  logic [DW-1:0]    img_q [DEPTH];
  logic [DW-1:0]    res_q [DEPTH];

  logic [2:0]       state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [CHK_W-1:0] checksum_q, checksum_d;
  logic [6:0]       wr_count_q, wr_count_d;
  logic             result_valid_q, result_valid_d;
  logic             res_we;
  logic             fire;
  logic [3:0]       cq_head;
  logic             cq_empty;

  // Old data is returned when a preload write hits the address being read.
  always_ff @(posedge clk) begin
    if (img_wr_en) img_q[img_wr_addr] <= img_wr_data;
  end

  assign IROM_Q = IROM_rd ? img_q[IROM_A] : '0;

  lcd_cmd_fifo #(
    .W     (4),
    .DEPTH (CQ_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cq_push),
    .push_data (cq_data),
    .pop       (fire),
    .head      (cq_head),
    .empty     (cq_empty),
    .full      (cq_full),
    .ovf       (cq_ovf)
  );

  // Issue is qualified by the live busy input so cmd_valid never overlaps busy.
  assign fire      = (state_q == ST_ISSUE) && !cq_empty && !busy;
  assign cmd_valid = fire;
  assign cmd       = fire ? cq_head : cmd_q;

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    checksum_d     = checksum_q;
    wr_count_d     = wr_count_q;
    result_valid_d = result_valid_q;
    res_we         = 1'b0;
    case (state_q)
      ST_LOAD:    if (!busy) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (fire) begin
          cmd_d   = cq_head;
          state_d = (cq_head == CMD_WRITE) ? ST_DRAIN : ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: if (busy)  state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!busy) state_d = ST_ISSUE;
      ST_DRAIN: begin
        if (IRAM_valid) begin
          res_we     = 1'b1;
          checksum_d = checksum_q + CHK_W'(IRAM_D);
          wr_count_d = (wr_count_q == FULL_CNT) ? wr_count_q : wr_count_q + 7'd1;
        end
        if (done) begin
          state_d        = ST_RESULT;
          result_valid_d = 1'b1;
        end
      end
      ST_RESULT:  state_d = ST_RESULT;
      default:    state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_LOAD;
      cmd_q          <= '0;
      checksum_q     <= '0;
      wr_count_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      checksum_q     <= checksum_d;
      wr_count_q     <= wr_count_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (res_we) res_q[IRAM_A] <= IRAM_D;
  end

  assign res_rd_data  = res_q[res_rd_addr];
  assign checksum     = checksum_q;
  assign wr_count     = wr_count_q;
  assign result_valid = result_valid_q;

`ifdef LCD_HOST_ORDER_CHECK_EN
  logic err_q, err_d;

  // The running capture count doubles as the expected next write-back address.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_DRAIN) begin
      if (IRAM_valid && (7'(IRAM_A) != wr_count_q)) err_d = 1'b1;
      if (done && (wr_count_d != FULL_CNT))         err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_host_agent.sv
// Directed self-checking bench for lcd_host_agent: ROM responder, command
// handshake, write-back capture, queue full/overflow, reset and order check.
module tb_lcd_host_agent;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          img_wr_en = 1'b0;
  logic [AW-1:0] img_wr_addr = '0;
  logic [DW-1:0] img_wr_data = '0;
  logic          cq_push = 1'b0;
  logic [3:0]    cq_data = '0;
  logic          cq_full, cq_ovf;
  logic          IROM_rd = 1'b0;
  logic [AW-1:0] IROM_A = '0;
  logic [DW-1:0] IROM_Q;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          busy = 1'b1;
  logic          IRAM_valid = 1'b0;
  logic [AW-1:0] IRAM_A = '0;
  logic [DW-1:0] IRAM_D = '0;
  logic          done = 1'b0;
  logic [AW-1:0] res_rd_addr = '0;
  logic [DW-1:0] res_rd_data;
  logic [13:0]   checksum;
  logic [6:0]    wr_count;
  logic          result_valid;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_host_agent dut (
    .clk          (clk),
    .reset        (reset),
    .img_wr_en    (img_wr_en),
    .img_wr_addr  (img_wr_addr),
    .img_wr_data  (img_wr_data),
    .cq_push      (cq_push),
    .cq_data      (cq_data),
    .cq_full      (cq_full),
    .cq_ovf       (cq_ovf),
    .IROM_rd      (IROM_rd),
    .IROM_A       (IROM_A),
    .IROM_Q       (IROM_Q),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .busy         (busy),
    .IRAM_valid   (IRAM_valid),
    .IRAM_A       (IRAM_A),
    .IRAM_D       (IRAM_D),
    .done         (done),
    .res_rd_addr  (res_rd_addr),
    .res_rd_data  (res_rd_data),
    .checksum     (checksum),
    .wr_count     (wr_count),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int max, output bit found);
    found = 1'b0;
    for (int n = 0; n < max; n++) begin
      #1;
      if (cmd_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    busy       = 1'b1;
    cq_push    = 1'b0;
    IRAM_valid = 1'b0;
    done       = 1'b0;
    img_wr_en  = 1'b0;
    IROM_rd    = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic push_cmd(input logic [3:0] c);
    cq_push = 1'b1;
    cq_data = c;
    cyc();
    cq_push = 1'b0;
  endtask

  task automatic iram_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    IRAM_valid = 1'b1;
    IRAM_A     = a;
    IRAM_D     = d;
    cyc();
    IRAM_valid = 1'b0;
  endtask

  bit   found;
  bit   stray;
  logic exp_err;

  initial begin
    // Reset values
    do_reset();
    #1;
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cq_full", cq_full, 0);
    check("rst_cq_ovf", cq_ovf, 0);
    check("rst_checksum", checksum, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_err", err, 0);

    // ROM preload and combinational read
    for (int i = 0; i < 64; i++) begin
      img_wr_en   = 1'b1;
      img_wr_addr = AW'(i);
      img_wr_data = DW'(i);
      cyc();
    end
    img_wr_en = 1'b0;
    IROM_rd   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      IROM_A = AW'(i);
      #1;
      check($sformatf("rom_rd_%0d", i), IROM_Q, i);
    end
    IROM_rd = 1'b0;
    IROM_A  = 6'd7;
    #1;
    check("rom_rd_disabled", IROM_Q, 0);

    // Same-cycle preload write and read: old data, then new
    IROM_rd     = 1'b1;
    IROM_A      = 6'd5;
    img_wr_en   = 1'b1;
    img_wr_addr = 6'd5;
    img_wr_data = 8'hAA;
    #1;
    check("rom_rw_old", IROM_Q, 8'h05);
    cyc();
    img_wr_en = 1'b0;
    #1;
    check("rom_rw_new", IROM_Q, 8'hAA);
    IROM_rd = 1'b0;

    // Write-back outside DRAIN is ignored
    iram_write(6'd10, 8'h11);
    check("iram_ignored_cnt", wr_count, 0);
    check("iram_ignored_sum", checksum, 0);

    // Command handshake: 3 then 0
    push_cmd(4'd3);
    push_cmd(4'd0);
    busy = 1'b0;
    wait_valid(10, found);
    check("issue1_found", found, 1);
    check("issue1_cmd", cmd, 3);
    cyc();
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (cmd_valid !== 1'b0) stray = 1'b1;
      cyc();
    end
    check("no_pulse_before_busy", stray, 0);
    check("cmd_hold", cmd, 3);
    busy = 1'b1;
    cyc();
    #1;
    check("no_pulse_while_busy", cmd_valid, 0);
    busy = 1'b0;
    wait_valid(10, found);
    check("issue2_found", found, 1);
    check("issue2_cmd", cmd, 0);
    cyc();

    // DRAIN: 64 x 0xFF, then done
    for (int i = 0; i < 64; i++) iram_write(AW'(i), 8'hFF);
    check("drain_cnt_pre_done", wr_count, 64);
    check("drain_rv_pre_done", result_valid, 0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    check("drain_checksum", checksum, 16320);
    check("drain_wr_count", wr_count, 64);
    check("drain_result_valid", result_valid, 1);
    check("drain_err", err, 0);
    res_rd_addr = 6'd10;
    #1;
    check("res_rd_10", res_rd_data, 8'hFF);
    iram_write(6'd10, 8'h00);
    #1;
    check("result_ignores_sum", checksum, 16320);
    check("result_ignores_res", res_rd_data, 8'hFF);

    // Queue full / overflow
    do_reset();
    for (int i = 0; i < 16; i++) push_cmd(4'd5);
    #1;
    check("fifo_full16", cq_full, 1);
    check("fifo_no_ovf16", cq_ovf, 0);
    busy = 1'b0;
    cyc();
    #1;
    check("fifo_pop_fire", cmd_valid, 1);
    cq_push = 1'b1;
    cq_data = 4'd6;
    cyc();
    cq_push = 1'b0;
    #1;
    check("fifo_pushpop_full", cq_full, 1);
    check("fifo_pushpop_ovf", cq_ovf, 0);
    push_cmd(4'd7);
    #1;
    check("fifo_ovf17", cq_ovf, 1);

    // Reset during WAIT_HI
    do_reset();
    push_cmd(4'd7);
    busy = 1'b0;
    wait_valid(10, found);
    check("rst_mid_issue", found, 1);
    cyc();
    push_cmd(4'd8);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs",
          {cmd, cmd_valid, cq_full, cq_ovf, checksum, wr_count, result_valid, err}, 0);
    cyc();
    reset = 1'b0;
    busy  = 1'b0;
    wait_valid(6, found);
    check("rst_mid_queue_empty", found, 0);

    // Write-back order check: addresses 0,1,3
`ifdef LCD_HOST_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    push_cmd(4'd0);
    busy = 1'b0;
    wait_valid(10, found);
    check("ord_issue", found, 1);
    cyc();
    iram_write(6'd0, 8'h01);
    iram_write(6'd1, 8'h01);
    check("ord_err_in_order", err, 0);
    iram_write(6'd3, 8'h01);
    check("ord_err_skip", err, 32'(exp_err));
    check("ord_wr_count", wr_count, 3);
    check("ord_checksum", checksum, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_host_agent.md
Name: lcd_host_agent

Overview:
- Acts as the system-side counterpart of the 8x8 LCD image controller.
- Serves the controller's image ROM read requests from a 64x8 image store.
- Issues queued 4-bit commands over the cmd/cmd_valid/busy handshake.
- Captures the 64-byte write-back burst into a result store, accumulates a checksum, and flags completion on the controller's done pulse.

Parameters:
- DW, 8, pixel data width.
- AW, 6, image address width (64 pixels).
- CQ_DEPTH, 16, command queue depth (power of 2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- img_wr_en  in  1  image store preload write strobe
- img_wr_addr  in  AW  preload address
- img_wr_data  in  DW  preload data
- cq_push  in  1  push command into queue
- cq_data  in  4  command code (0 = write-back/finish)
- cq_full  out  1  queue full
- cq_ovf  out  1  sticky: push attempted while full
- IROM_rd  in  1  controller ROM read enable
- IROM_A  in  AW  controller ROM address
- IROM_Q  out  DW  ROM read data
- cmd  out  4  command to controller
- cmd_valid  out  1  command strobe, single cycle
- busy  in  1  controller busy
- IRAM_valid  in  1  controller write-back strobe
- IRAM_A  in  AW  write-back address
- IRAM_D  in  DW  write-back data
- done  in  1  controller completion pulse
- res_rd_addr  in  AW  result store read address
- res_rd_data  out  DW  result store data (combinational)
- checksum  out  14  sum of captured bytes
- wr_count  out  7  captured byte count
- result_valid  out  1  high after done seen, until reset
- err  out  1  sticky write-back order error

Behaviour:
- Reset values:
  - cmd=0, cmd_valid=0, cq_full=0, cq_ovf=0.
  - checksum=0, wr_count=0, result_valid=0, err=0.
  - Queue empty, FSM in LOAD.
  - Image and result stores are not reset.
- ROM responder:
  - IROM_Q = img[IROM_A] combinationally while IROM_rd=1, else 0.
  - Preload write and IROM read to the same address in the same cycle: the read returns the old value; the write lands at the clock edge.
- Command queue:
  - Synchronous FIFO.
  - A push when full is dropped and sets cq_ovf.
  - Push and pop in the same cycle when full is legal: the pop frees a slot, so the push is accepted.
- FSM states: LOAD, ISSUE, WAIT_HI, WAIT_LO, DRAIN, RESULT.
  - LOAD: wait for busy=0 (ROM load finished) -> ISSUE.
  - ISSUE: if queue non-empty and busy=0, drive cmd=head and cmd_valid=1 for exactly one cycle, then pop. Next state: cmd==0 -> DRAIN, else -> WAIT_HI. If the queue is empty, hold with cmd_valid=0.
  - WAIT_HI: wait for busy=1 -> WAIT_LO.
  - WAIT_LO: wait for busy=0 -> ISSUE.
  - This guarantees at most one outstanding command; cmd_valid is never asserted while busy=1.
  - DRAIN: on each IRAM_valid, write res[IRAM_A]=IRAM_D, checksum += IRAM_D (14-bit, no saturation), wr_count += 1 (saturates at 64). On done=1 -> RESULT.
  - RESULT: result_valid=1; ignore further IRAM_valid and done; hold until reset.
- IRAM_valid outside DRAIN is ignored, with no capture.
- Reset asserted mid-operation returns to LOAD with the queue flushed and all outputs at reset values.
- cmd holds its last issued value when cmd_valid=0.

Optional Feature:
- Macro: LCD_HOST_ORDER_CHECK_EN.
- Defined: in DRAIN, each IRAM_valid must have IRAM_A equal to the expected address (starts at 0, increments per write). On mismatch, or done arriving with wr_count!=64, err is set and stays set until reset.
- Undefined: no checker logic is present and err is tied to 0.

Decomposition:
- Shared package lcd_pkg holds:
  - Command codes: CMD_WRITE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, MAX=5, MIN=6, AVG=7, CCW=8, CW=9, MIRX=10, MIRY=11.
  - Host FSM state encoding.
  - Constants IMG_PIXELS=64 and CHK_W=14.
- One sub-module: lcd_cmd_fifo (parameterised queue with full/empty/overflow).

Test Plan:
- Preload img[i]=i, then drive IROM_rd=1 with IROM_A=0..63 -> IROM_Q=0..63 on the same cycle; IROM_rd=0 -> IROM_Q=0.
- Queue 3,0 with busy falling after load -> cmd_valid pulses with cmd=3; no second pulse until busy goes 1 then 0; then cmd=0 pulse; FSM enters DRAIN.
- DRAIN with 64 writes IRAM_A=0..63, IRAM_D=0xFF, then done -> checksum=16320 (0x3FC0), wr_count=64, result_valid=1, res_rd_addr=10 gives 0xFF.
- Push 17 commands with no pops (CQ_DEPTH=16) -> cq_full=1 after 16, cq_ovf=1 after 17th; push+pop in the same cycle while full -> cq_ovf unchanged.
- Assert reset during WAIT_HI -> all outputs at reset values, queue empty, FSM in LOAD.
- With LCD_HOST_ORDER_CHECK_EN: DRAIN with IRAM_A sequence 0,1,3 -> err=1 on the third write; without the macro -> err stays 0.
